vga_timing_out: RTL and testbench

- Generates 640x480@60 VGA raster timing and drives the physical VGA pins.
- Upstream: supplies sx/sy to the square painters.
- Downstream: consumes their combinational paint_r/g/b, blanks outside the active area, and registers colour together with sync so pins stay aligned.
- Top level instantiates one of these per display.

---
 rtl/vga_timing_out.sv | 134 +++++++++++++
 tb/tb_vga_timing_out.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_out.sv
// vga_timing_out: VGA raster timing generator and pin driver.
//
// Produces the sx/sy raster position for the painters, decodes display-enable
// and the two sync pulses from that position, and registers colour, sync and
// display-enable together so every pin shows the same pixel on the same clk.
//
// Ports:
//   clk, rst              clock (rising edge) and asynchronous active-high reset
//   sx, sy                current raster position, advanced on pix_stb
//   pix_stb               one-clk pulse on the cycle where sx/sy advance
//   frame_start           pix_stb cycle at sx==0, sy==V_ACTIVE (start of vblank)
//   paint_r/g/b           colour from the painters, combinational in sx/sy
//   vga_r/g/b             registered colour, forced to 0 outside the active area
//   vga_hs, vga_vs        registered sync, active level set by SYNC_POL
//   vga_de                registered display-enable
module vga_timing_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 1,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] sx,
  output logic [9:0] sy,
  output logic       pix_stb,
  output logic       frame_start,
  input  logic [3:0] paint_r,
  input  logic [3:0] paint_g,
  input  logic [3:0] paint_b,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024) begin : g_h_total_chk
    $error("vga_timing_out: H_TOTAL %0d does not fit a 10-bit counter", H_TOTAL);
  end
  if (V_TOTAL > 1024) begin : g_v_total_chk
    $error("vga_timing_out: V_TOTAL %0d does not fit a 10-bit counter", V_TOTAL);
  end
  if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_div_chk
    $error("vga_timing_out: CLK_DIV %0d outside 1..4", CLK_DIV);
  end

  // Thresholds are held at 11 bits so a boundary equal to 1024 is still
  // representable; the counters are zero-extended to match.
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [1:0]  DIV_LAST = 2'(CLK_DIV - 1);
  localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_W  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG_W = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END_W = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG_W = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END_W = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [1:0]  div_cnt;
  logic [10:0] sx_w;
  logic [10:0] sy_w;
  logic        de_p0;
  logic        hs_p0;
  logic        vs_p0;

  // Pixel-rate divider. The strobe is masked while rst is high so that with
  // CLK_DIV=1 it does not read as active during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 2'd1;
    end
  end

  assign pix_stb = ~rst & (div_cnt == DIV_LAST);

  // Raster counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx <= '0;
      sy <= '0;
    end else if (pix_stb) begin
      if (sx == H_LAST) begin
        sx <= '0;
        sy <= (sy == V_LAST) ? 10'd0 : sy + 10'd1;
      end else begin
        sx <= sx + 10'd1;
      end
    end
  end

  // Stage p0: combinational decode of the current position
  assign sx_w  = {1'b0, sx};
  assign sy_w  = {1'b0, sy};
  assign de_p0 = (sx_w < H_ACT_W) && (sy_w < V_ACT_W);
  assign hs_p0 = (sx_w >= HS_BEG_W) && (sx_w < HS_END_W);
  assign vs_p0 = (sy_w >= VS_BEG_W) && (sy_w < VS_END_W);

  assign frame_start = pix_stb && (sx == 10'd0) && (sy_w == V_ACT_W);

  // Stage p1: pin register, one pixel behind sx/sy for every output alike
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_de <= 1'b0;
      vga_hs <= ~SYNC_POL;
      vga_vs <= ~SYNC_POL;
    end else if (pix_stb) begin
      vga_r  <= de_p0 ? paint_r : 4'h0;
      vga_g  <= de_p0 ? paint_g : 4'h0;
      vga_b  <= de_p0 ? paint_b : 4'h0;
      vga_de <= de_p0;
      vga_hs <= hs_p0 ? SYNC_POL : ~SYNC_POL;
      vga_vs <= vs_p0 ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_vga_timing_out.sv
// tb_vga_timing_out: bench for vga_timing_out.
// Two instances share one clock: index 0 uses the default 640x480 timing with
// CLK_DIV=1, index 1 uses a shrunken raster with CLK_DIV=3 and active-high
// sync so whole frames, vsync and frame_start fit in a short run. The model
// derives the expected raster position from the number of clk edges since
// reset release, and expected pins from the position and paint at each strobe.
module tb_vga_timing_out;

  logic       clk = 1'b0;
  logic       rst   [2];
  logic [9:0] sx_o  [2];
  logic [9:0] sy_o  [2];
  logic       stb_o [2];
  logic       fs_o  [2];
  logic       hs_o  [2];
  logic       vs_o  [2];
  logic       de_o  [2];
  logic [3:0] pr    [2];
  logic [3:0] pg    [2];
  logic [3:0] pb    [2];
  logic [3:0] r_o   [2];
  logic [3:0] g_o   [2];
  logic [3:0] b_o   [2];

  int ha [2] = '{640, 20};
  int hf [2] = '{16, 3};
  int hw [2] = '{96, 5};
  int hb [2] = '{48, 4};
  int va [2] = '{480, 6};
  int vf [2] = '{10, 2};
  int vw [2] = '{2, 2};
  int vb [2] = '{33, 3};
  int cd [2] = '{1, 3};
  bit pol[2] = '{1'b0, 1'b1};

  int         k      [2];
  int         last_fs[2];
  int         fs_cnt [2];
  logic [3:0] er [2];
  logic [3:0] eg [2];
  logic [3:0] eb [2];
  logic       ehs[2];
  logic       evs[2];
  logic       ede[2];
  int         nchk = 0;
  int         nerr = 0;
  bit         found;

  always #5 clk = ~clk;

  vga_timing_out u_dut_std (
    .clk(clk), .rst(rst[0]), .sx(sx_o[0]), .sy(sy_o[0]), .pix_stb(stb_o[0]),
    .frame_start(fs_o[0]), .paint_r(pr[0]), .paint_g(pg[0]), .paint_b(pb[0]),
    .vga_r(r_o[0]), .vga_g(g_o[0]), .vga_b(b_o[0]),
    .vga_hs(hs_o[0]), .vga_vs(vs_o[0]), .vga_de(de_o[0])
  );

  vga_timing_out #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CLK_DIV(3), .SYNC_POL(1'b1)
  ) u_dut_small (
    .clk(clk), .rst(rst[1]), .sx(sx_o[1]), .sy(sy_o[1]), .pix_stb(stb_o[1]),
    .frame_start(fs_o[1]), .paint_r(pr[1]), .paint_g(pg[1]), .paint_b(pb[1]),
    .vga_r(r_o[1]), .vga_g(g_o[1]), .vga_b(b_o[1]),
    .vga_hs(hs_o[1]), .vga_vs(vs_o[1]), .vga_de(de_o[1])
  );

  function automatic int htot(int d);
    return ha[d] + hf[d] + hw[d] + hb[d];
  endfunction

  function automatic int vtot(int d);
    return va[d] + vf[d] + vw[d] + vb[d];
  endfunction

  // Pixels completed after kk edges is kk/CLK_DIV; position follows from that.
  function automatic int hpos(int d, int kk);
    return (kk / cd[d]) % htot(d);
  endfunction

  function automatic int vpos(int d, int kk);
    return ((kk / cd[d]) / htot(d)) % vtot(d);
  endfunction

  task automatic check(input string tag, input int d, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got %0d expected %0d at t=%0t", tag, d, got, exp, $time);
    end
  endtask

  task automatic drive_paint(input int d);
    if ($urandom_range(3) == 0) begin
      pr[d] = 4'hF; pg[d] = 4'hF; pb[d] = 4'hF;
    end else begin
      pr[d] = 4'($urandom); pg[d] = 4'($urandom); pb[d] = 4'($urandom);
    end
  endtask

  // Actions of the clk window k: new paint, and on a strobe capture what the
  // pins must show after the coming edge.
  task automatic advance(input int d);
    int hp;
    int vp;
    bit de;
    drive_paint(d);
    if ((k[d] % cd[d]) == cd[d] - 1) begin
      hp = hpos(d, k[d]);
      vp = vpos(d, k[d]);
      de = (hp < ha[d]) && (vp < va[d]);
      er[d]  = de ? pr[d] : 4'h0;
      eg[d]  = de ? pg[d] : 4'h0;
      eb[d]  = de ? pb[d] : 4'h0;
      ede[d] = de;
      ehs[d] = (hp >= ha[d] + hf[d] && hp < ha[d] + hf[d] + hw[d]) ? pol[d] : !pol[d];
      evs[d] = (vp >= va[d] + vf[d] && vp < va[d] + vf[d] + vw[d]) ? pol[d] : !pol[d];
    end
    k[d]++;
  endtask

  task automatic step(input int d);
    int hp;
    int vp;
    bit stb;
    bit fs;
    if (rst[d]) begin
      check("rst_stb", d, stb_o[d], 0);
      check("rst_fs", d, fs_o[d], 0);
      check("rst_sx", d, sx_o[d], 0);
      check("rst_sy", d, sy_o[d], 0);
      check("rst_rgb", d, {r_o[d], g_o[d], b_o[d]}, 0);
      check("rst_de", d, de_o[d], 0);
      check("rst_hs", d, hs_o[d], !pol[d]);
      check("rst_vs", d, vs_o[d], !pol[d]);
      k[d] = 0;
      last_fs[d] = -1;
      er[d] = 4'h0; eg[d] = 4'h0; eb[d] = 4'h0;
      ede[d] = 1'b0; ehs[d] = !pol[d]; evs[d] = !pol[d];
      drive_paint(d);
    end else begin
      hp  = hpos(d, k[d]);
      vp  = vpos(d, k[d]);
      stb = (k[d] % cd[d]) == cd[d] - 1;
      fs  = stb && hp == 0 && vp == va[d];
      check("sx", d, sx_o[d], hp);
      check("sy", d, sy_o[d], vp);
      check("pix_stb", d, stb_o[d], stb);
      check("frame_start", d, fs_o[d], fs);
      check("vga_r", d, r_o[d], er[d]);
      check("vga_g", d, g_o[d], eg[d]);
      check("vga_b", d, b_o[d], eb[d]);
      check("vga_de", d, de_o[d], ede[d]);
      check("vga_hs", d, hs_o[d], ehs[d]);
      check("vga_vs", d, vs_o[d], evs[d]);
      if (fs) begin
        if (last_fs[d] >= 0)
          check("fs_period", d, k[d] - last_fs[d], htot(d) * vtot(d) * cd[d]);
        last_fs[d] = k[d];
        fs_cnt[d]++;
      end
      advance(d);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      k[d] = 0; last_fs[d] = -1; fs_cnt[d] = 0;
      pr[d] = 4'h0; pg[d] = 4'h0; pb[d] = 4'h0;
    end

    repeat (3) begin @(negedge clk); step(0); step(1); end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    advance(0);
    advance(1);

    repeat (5000) begin @(negedge clk); step(0); step(1); end

    // Reach a pixel inside both sync pulses on the small raster, then reset
    // between clk edges.
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk); step(0); step(1);
      if (hpos(1, k[1] - 1) == ha[1] + hf[1] + 1 && vpos(1, k[1] - 1) == va[1] + vf[1])
        found = 1'b1;
    end
    check("async_target", 1, found, 1);
    if (found) begin
      check("pre_rst_hs", 1, hs_o[1], pol[1]);
      check("pre_rst_vs", 1, vs_o[1], pol[1]);
      #2 rst[1] = 1'b1;
      #1;
      check("async_sx", 1, sx_o[1], 0);
      check("async_sy", 1, sy_o[1], 0);
      check("async_hs", 1, hs_o[1], !pol[1]);
      check("async_vs", 1, vs_o[1], !pol[1]);
      check("async_de", 1, de_o[1], 0);
      check("async_stb", 1, stb_o[1], 0);
      check("async_fs", 1, fs_o[1], 0);
    end

    repeat (4) begin @(negedge clk); step(0); step(1); end
    rst[1] = 1'b0;
    advance(1);

    repeat (3000) begin @(negedge clk); step(0); step(1); end

    check("frames_seen", 1, (fs_cnt[1] >= 6) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
